dte_diag_seq: RTL

DTE_DIAG_SEQ -- requirements
Module: dte_diag_seq

---
 rtl/dte_diag_seq.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/dte_diag_seq.sv
// DTE diagnostic sequencer: per-channel request FIFOs, round-robin arbiter and an
// EBUS diag-cycle FSM with misc (CROBAR) handling and a held reply port.
module dte_diag_seq #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned DW      = 36,
    parameter int unsigned STB_CYC = 2,
    parameter int unsigned RD_LAT  = 2,
    localparam int unsigned CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    req_valid,
    output logic [NCH-1:0]    req_ready,
    input  logic [2*NCH-1:0]  req_type,
    input  logic [7*NCH-1:0]  req_diag,
    input  logic [DW*NCH-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [CW-1:0]     rsp_ch,
    output logic [1:0]        rsp_type,
    output logic [6:0]        rsp_diag,
    output logic [DW-1:0]     rsp_data,
    output logic [6:0]        ebus_ds,
    output logic              ebus_diag_strobe,
    output logic              ebus_drive,
    output logic [DW-1:0]     ebus_data_out,
    input  logic [DW-1:0]     ebus_data_in,
    output logic              crobar,
    output logic              busy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned EW = 9 + DW;

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StWait, StCapture, StReply} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [CW-1:0]   last_q, last_d;
    logic [CW-1:0]   cmd_ch_q, cmd_ch_d;
    logic [1:0]      cmd_type_q, cmd_type_d;
    logic [6:0]      cmd_diag_q, cmd_diag_d;
    logic [DW-1:0]   cmd_data_q, cmd_data_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            crobar_q, crobar_d;

    logic [EW-1:0]   mem_q [NCH][DEPTH];
    logic [PW-1:0]   wr_ptr_q [NCH];
    logic [PW-1:0]   rd_ptr_q [NCH];
    logic [PW:0]     fifo_cnt_q [NCH];
    logic [NCH-1:0]  push, pop, nonempty;

    logic            gnt_any, found_hi, found_lo;
    logic [CW-1:0]   gnt_ch, hi_ch, lo_ch;
    logic [EW-1:0]   head;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            nonempty[c]  = fifo_cnt_q[c] != '0;
            req_ready[c] = fifo_cnt_q[c] != (PW+1)'(DEPTH);
            push[c]      = req_valid[c] & req_ready[c];
        end
    end

    // Lowest non-empty channel above the last grant wins; otherwise wrap to the lowest overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_ch    = '0;
        lo_ch    = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (nonempty[c]) begin
                if (CW'(c) > last_q) begin
                    found_hi = 1'b1;
                    hi_ch    = CW'(c);
                end else begin
                    found_lo = 1'b1;
                    lo_ch    = CW'(c);
                end
            end
        end
        gnt_any = found_hi | found_lo;
        gnt_ch  = found_hi ? hi_ch : lo_ch;
        head    = mem_q[gnt_ch][rd_ptr_q[gnt_ch]];
        for (int c = 0; c < NCH; c++) begin
            pop[c] = (state_q == StIdle) && gnt_any && (gnt_ch == CW'(c));
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (push[c]) begin
                mem_q[c][wr_ptr_q[c]] <= {req_type[2*c +: 2], req_diag[7*c +: 7], req_data[DW*c +: DW]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                wr_ptr_q[c]   <= '0;
                rd_ptr_q[c]   <= '0;
                fifo_cnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
                if (pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
                if (push[c] && !pop[c])      fifo_cnt_q[c] <= fifo_cnt_q[c] + 1'b1;
                else if (pop[c] && !push[c]) fifo_cnt_q[c] <= fifo_cnt_q[c] - 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        cmd_ch_d   = cmd_ch_q;
        cmd_type_d = cmd_type_q;
        cmd_diag_d = cmd_diag_q;
        cmd_data_d = cmd_data_q;
        rsp_data_d = rsp_data_q;
        crobar_d   = crobar_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_any) begin
                    last_d     = gnt_ch;
                    cmd_ch_d   = gnt_ch;
                    cmd_type_d = head[DW+8 -: 2];
                    cmd_diag_d = head[DW+6 -: 7];
                    cmd_data_d = head[DW-1:0];
                    rsp_data_d = '0;
                    if (head[DW+8 -: 2] == 2'd3) begin
                        state_d = StReply;
                        if (head[DW+6 -: 7] == 7'd0)      crobar_d = 1'b0;
                        else if (head[DW+6 -: 7] == 7'd1) crobar_d = 1'b1;
                    end else begin
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                state_d = StStrobe;
                cnt_d   = 4'(STB_CYC - 1);
            end
            StStrobe: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (RD_LAT == 0) begin
                    state_d = StCapture;
                end else begin
                    state_d = StWait;
                    cnt_d   = 4'(RD_LAT - 1);
                end
            end
            StWait: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             state_d = StCapture;
            end
            StCapture: begin
                if (cmd_type_q == 2'd1) rsp_data_d = ebus_data_in;
                state_d = StReply;
            end
            StReply: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            last_q     <= CW'(NCH - 1);
            cmd_ch_q   <= '0;
            cmd_type_q <= '0;
            cmd_diag_q <= '0;
            cmd_data_q <= '0;
            rsp_data_q <= '0;
            crobar_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            cmd_ch_q   <= cmd_ch_d;
            cmd_type_q <= cmd_type_d;
            cmd_diag_q <= cmd_diag_d;
            cmd_data_q <= cmd_data_d;
            rsp_data_q <= rsp_data_d;
            crobar_q   <= crobar_d;
        end
    end

    // EBUS outputs decode straight from state so reset drops them asynchronously.
    always_comb begin
        busy             = state_q != StIdle;
        rsp_valid        = state_q == StReply;
        ebus_diag_strobe = state_q == StStrobe;
        ebus_ds          = (state_q inside {StSetup, StStrobe, StWait, StCapture}) ? cmd_diag_q : 7'd0;
        ebus_drive       = (cmd_type_q == 2'd2) && (state_q inside {StSetup, StStrobe, StWait});
        ebus_data_out    = ebus_drive ? cmd_data_q : '0;
        rsp_ch           = cmd_ch_q;
        rsp_type         = cmd_type_q;
        rsp_diag         = cmd_diag_q;
        rsp_data         = rsp_data_q;
        crobar           = crobar_q;
    end

endmodule
